// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg -- shared types and helpers for the sequential shift-add multiplier.
//   state_t   : controller states (IDLE, BUSY, DONE)
//   cnt_width : bit-counter width for a given operand width ($clog2(WIDTH), min 1)
package seq_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/seq_mul_add.sv
// seq_mul_add -- WIDTH-bit combinational ripple-carry adder built from
// full_adder cells; sum plus carry-out, carry-in tied low.
//   a, b : addends (WIDTH)
//   sum  : a + b, low WIDTH bits
//   co   : carry out of the top cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module seq_mul_add #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             co
);

   logic [WIDTH:0] c;

   assign c[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign co = c[WIDTH];

endmodule

// File: rtl/seq_mul.sv
// seq_mul -- sequential shift-add multiplier, one multiplier bit per clock.
// Signed operands are reduced to magnitudes at accept; the sign is
// reapplied to the 2*WIDTH-bit product on the edge entering DONE.
// Optional build macro: SEQ_MUL_EARLY_EXIT_EN (finish as soon as the
// remaining multiplier bits are zero; results are identical).
//   clk, rst_n            : clock, async active-low reset
//   in_valid / in_ready   : operand handshake (in_signed, x, y)
//   out_valid / out_ready : product handshake (out)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one shift-add step per edge, cnt = step index
// DONE  | product held on out, out_valid=1 until consumed
module seq_mul
   import seq_mul_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out
);

   localparam int               CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   mcand;
   logic [WIDTH-1:0]   mlt;
   // Bit 0 of the running accumulator is always zero before the final
   // shift, so only bits 2W-1..1 are stored.
   logic [2*WIDTH-1:1] acc;
   logic [2*WIDTH-1:0] out_q;
   logic               neg;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   x_mag;
   logic [WIDTH-1:0]   y_mag;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH-1:0]   sum;
   logic               carry;
   logic [2*WIDTH-1:0] acc_step;
   logic [2*WIDTH-1:0] acc_final;
   logic [2*WIDTH-1:0] result;
   logic               finish;

   // Most-negative input maps to 2^(WIDTH-1), which fits unsigned.
   assign x_mag = (in_signed && x[WIDTH-1]) ? (~x + 1'b1) : x;
   assign y_mag = (in_signed && y[WIDTH-1]) ? (~y + 1'b1) : y;

   assign addend = mlt[0] ? mcand : '0;

   seq_mul_add #(.WIDTH(WIDTH)) u_add (
      .a   (acc[2*WIDTH-1:WIDTH]),
      .b   (addend),
      .sum (sum),
      .co  (carry)
   );

   assign acc_step = {carry, sum, acc[WIDTH-1:1]};

`ifdef SEQ_MUL_EARLY_EXIT_EN
   logic [CNT_W-1:0] rem;
   logic             rest_zero;

   // Remaining steps would only shift, so apply them all at once.
   assign rest_zero = (mlt[WIDTH-1:1] == '0);
   assign rem       = LAST - cnt;
   assign finish    = rest_zero || (cnt == LAST);
   assign acc_final = acc_step >> rem;
`else
   assign finish    = (cnt == LAST);
   assign acc_final = acc_step;
`endif

   assign result = neg ? (~acc_final + 1'b1) : acc_final;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         mcand <= '0;
         mlt   <= '0;
         acc   <= '0;
         neg   <= 1'b0;
         cnt   <= '0;
         out_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand <= x_mag;
                  mlt   <= y_mag;
                  acc   <= '0;
                  neg   <= in_signed && (x[WIDTH-1] ^ y[WIDTH-1]);
                  cnt   <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc <= acc_step[2*WIDTH-1:1];
               mlt <= mlt >> 1;
               cnt <= cnt + 1'b1;
               if (finish) begin
                  out_q <= result;
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out       = out_q;

endmodule

// File: tb/tb_seq_mul.sv
module tb_seq_mul;

   localparam int W  = 4;
   localparam int PW = 2 * W;
`ifdef SEQ_MUL_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_signed;
   logic [W-1:0]  x;
   logic [W-1:0]  y;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out;

   int checks = 0;
   int errors = 0;

   seq_mul #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_signed (in_signed),
      .x         (x),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         nm;
      logic          s;
      logic [W-1:0]  a;
      logic [W-1:0]  b;
      logic [PW-1:0] p;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: plain integer multiply of the interpreted operands.
   function automatic logic [PW-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      longint ia;
      longint ib;
      ia = longint'(a);
      ib = longint'(b);
      if (s && a[W-1]) ia = ia - (longint'(1) << W);
      if (s && b[W-1]) ib = ib - (longint'(1) << W);
      return PW'(ia * ib);
   endfunction

   function automatic int exp_lat(input logic s, input logic [W-1:0] b);
      int mag;
      int l;
      mag = int'(b);
      if (s && b[W-1]) mag = (1 << W) - mag;
      l = 1;
      for (int i = 0; i < W; i++)
         if ((mag >> i) % 2 == 1) l = i + 1;
      return EARLY ? l : W;
   endfunction

   task automatic run_op(input string nm, input logic s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [PW-1:0] p);
      int lat;
      @(negedge clk);
      chk({nm, "_in_ready_idle"}, in_ready, 1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_signed = s;
      x = a;
      y = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_latency"}, lat, exp_lat(s, b));
      chk({nm, "_out"}, out, p);
      chk({nm, "_in_ready_done"}, in_ready, 0);
      @(negedge clk);
      chk({nm, "_valid_drop"}, out_valid, 0);
      chk({nm, "_in_ready_back"}, in_ready, 1);
      chk({nm, "_out_hold"}, out, p);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          vecs[$];
      logic [PW-1:0] q[$];
      logic [PW-1:0] exp_p;
      logic [9:0]    k;
      int            lat;
      int            idx;
      int            got;
      int            cyc;

      vecs.push_back('{"u_15x15",  1'b0, 4'hF, 4'hF, 8'hE1});
      vecs.push_back('{"s_m8xm8",  1'b1, 4'h8, 4'h8, 8'h40});
      vecs.push_back('{"s_m8x7",   1'b1, 4'h8, 4'h7, 8'hC8});
      vecs.push_back('{"s_3xm1",   1'b1, 4'h3, 4'hF, 8'hFD});
      vecs.push_back('{"s_m1xm1",  1'b1, 4'hF, 4'hF, 8'h01});
      vecs.push_back('{"s_7x7",    1'b1, 4'h7, 4'h7, 8'h31});
      vecs.push_back('{"u_0x9",    1'b0, 4'h0, 4'h9, 8'h00});
      vecs.push_back('{"s_0xm1",   1'b1, 4'h0, 4'hF, 8'h00});
      vecs.push_back('{"u_13x1",   1'b0, 4'hD, 4'h1, 8'h0D});
      vecs.push_back('{"u_13x0",   1'b0, 4'hD, 4'h0, 8'h00});
      vecs.push_back('{"u_13x8",   1'b0, 4'hD, 4'h8, 8'h68});

      rst_n = 1'b1;
      in_valid = 1'b0;
      in_signed = 1'b0;
      x = '0;
      y = '0;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out", out, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++)
         run_op(vecs[i].nm, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].p);

      // Backpressure: product held, new operands refused until consumed.
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_signed = 1'b0;
      x = 4'd6;
      y = 4'd5;
      @(negedge clk);
      x = 4'd2;
      y = 4'd2;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_latency", lat, exp_lat(1'b0, 4'd5));
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid_held", out_valid, 1);
         chk("bp_out_stable", out, 8'h1E);
         chk("bp_in_ready_low", in_ready, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", out_valid, 0);
      chk("bp_release_in_ready", in_ready, 1);
      chk("bp_release_out_hold", out, 8'h1E);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_next_accepted", in_ready, 0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("bp_next_out", out, 8'h04);
      @(negedge clk);

      // Reset during the second BUSY cycle abandons the operation.
      in_valid  = 1'b1;
      in_signed = 1'b0;
      x = 4'd9;
      y = 4'd9;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_busy_out_valid", out_valid, 0);
      chk("rst_busy_out", out, 0);
      chk("rst_busy_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("after_reset_2x3", 1'b0, 4'd2, 4'd3, 8'h06);

      // Exhaustive sweep, both modes, random consumer backpressure.
      idx = 0;
      got = 0;
      cyc = 0;
      in_valid = 1'b0;
      while ((idx < 512 || got < 512) && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("sweep_unexpected_output", out, 'x);
            end else begin
               exp_p = q.pop_front();
               chk("sweep_product", out, exp_p);
            end
            got++;
         end
         if (in_ready) begin
            if (idx < 512) begin
               k = 10'(idx);
               in_valid  = 1'b1;
               in_signed = k[8];
               x = k[7:4];
               y = k[3:0];
               q.push_back(model(k[8], k[7:4], k[3:0]));
               idx++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      chk("sweep_count", got, 512);
      chk("sweep_queue_empty", q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
